react_avg: RTL and testbench

REACT_AVG -- requirements
Module: react_avg

---
 rtl/react_avg_pkg.sv | 21 ++
 rtl/react_acc.sv | 56 +++++
 rtl/react_avg.sv | 87 ++++++++
 tb/tb_react_avg.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/react_avg_pkg.sv
// Shared project definitions: controller state encoding, player select values, trial count.
package react_avg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT      = 3'd1,
      ST_CLR_CNT1  = 3'd2,
      ST_START     = 3'd3,
      ST_STORAGE   = 3'd4,
      ST_CLR_CNT2  = 3'd5,
      ST_AVERAGE   = 3'd6,
      ST_COMPARE   = 3'd7
   } state_t;

   localparam logic PLAYER_A = 1'b1;
   localparam logic PLAYER_B = 1'b0;

   localparam int TRIALS_LOG2_DEF = 3;
   localparam int TRIALS          = 2 ** TRIALS_LOG2_DEF;

endpackage

// File: rtl/react_acc.sv
// Per-player accumulator: running sum, trial index, done flag and held average.
module react_acc #(
   parameter int TIME_W      = 10,
   parameter int TRIALS_LOG2 = 3
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   clr,
   input  logic                   store,
   input  logic [TIME_W-1:0]      sample,
   input  logic                   avg_load,
   output logic [TRIALS_LOG2-1:0] test_turn,
   output logic [TIME_W-1:0]      avr_react_time,
   output logic                   done,
   output logic                   avg_valid
);

   localparam int SUM_W = TIME_W + TRIALS_LOG2;
   localparam logic [TRIALS_LOG2-1:0] LAST_TURN = '1;

   logic [SUM_W-1:0] sum;
   logic             load_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sum            <= '0;
         test_turn      <= '0;
         done           <= 1'b0;
         avr_react_time <= '0;
         load_d         <= 1'b0;
         avg_valid      <= 1'b0;
      end else if (clr) begin
         sum            <= '0;
         test_turn      <= '0;
         done           <= 1'b0;
         avr_react_time <= '0;
         load_d         <= 1'b0;
         avg_valid      <= 1'b0;
      end else begin
         if (store && !done) begin
            sum <= sum + SUM_W'(sample);
            if (test_turn == LAST_TURN)
               done <= 1'b1;
            else
               test_turn <= test_turn + 1'b1;
         end
         // Average is a pure shift; the valid flag trails the load by one cycle.
         if (avg_load && done)
            avr_react_time <= sum[SUM_W-1:TRIALS_LOG2];
         load_d <= avg_load && done;
         if (load_d)
            avg_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/react_avg.sv
// Reaction-time averaging: one-store-per-visit guard, AVERAGE edge detect, clamp, player steering.
module react_avg
   import react_avg_pkg::*;
#(
   parameter int TIME_W      = 10,
   parameter int TIME_MAX    = 999,
   parameter int TRIALS_LOG2 = TRIALS_LOG2_DEF
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [2:0]             machine_state,
   input  logic                   cur_player,
   input  logic [TIME_W-1:0]      react_time,
   input  logic                   react_valid,
   output logic [TRIALS_LOG2-1:0] test_turn_A,
   output logic [TRIALS_LOG2-1:0] test_turn_B,
   output logic [TIME_W-1:0]      avr_react_time_A,
   output logic [TIME_W-1:0]      avr_react_time_B,
   output logic                   done_A,
   output logic                   done_B,
   output logic                   avg_valid_A,
   output logic                   avg_valid_B
);

   localparam logic [TIME_W-1:0] TIME_CEIL = TIME_W'(TIME_MAX);

   function automatic logic [TIME_W-1:0] clamp_time(input logic [TIME_W-1:0] t);
      return (t > TIME_CEIL) ? TIME_CEIL : t;
   endfunction

   state_t            cur_state;
   state_t            prev_state;
   logic              guard;
   logic              in_storage;
   logic              clr;
   logic              store_hit;
   logic              avg_start;
   logic [TIME_W-1:0] sample;

   assign cur_state  = state_t'(machine_state);
   assign in_storage = (cur_state == ST_STORAGE);
   assign clr        = (cur_state == ST_IDLE);
   assign store_hit  = react_valid && in_storage && !guard;
   assign avg_start  = (cur_state == ST_AVERAGE) && (prev_state != ST_AVERAGE);
   assign sample     = clamp_time(react_time);

   // Guard is shared by both players so a player switch inside one visit cannot store twice.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         guard      <= 1'b0;
         prev_state <= ST_IDLE;
      end else begin
         prev_state <= cur_state;
         if (!in_storage)
            guard <= 1'b0;
         else if (react_valid)
            guard <= 1'b1;
      end
   end

   react_acc #(.TIME_W(TIME_W), .TRIALS_LOG2(TRIALS_LOG2)) u_acc_a (
      .clk            (clk),
      .rstn           (rstn),
      .clr            (clr),
      .store          (store_hit && (cur_player == PLAYER_A)),
      .sample         (sample),
      .avg_load       (avg_start && (cur_player == PLAYER_A)),
      .test_turn      (test_turn_A),
      .avr_react_time (avr_react_time_A),
      .done           (done_A),
      .avg_valid      (avg_valid_A)
   );

   react_acc #(.TIME_W(TIME_W), .TRIALS_LOG2(TRIALS_LOG2)) u_acc_b (
      .clk            (clk),
      .rstn           (rstn),
      .clr            (clr),
      .store          (store_hit && (cur_player == PLAYER_B)),
      .sample         (sample),
      .avg_load       (avg_start && (cur_player == PLAYER_B)),
      .test_turn      (test_turn_B),
      .avr_react_time (avr_react_time_B),
      .done           (done_B),
      .avg_valid      (avg_valid_B)
   );

endmodule

// File: tb/tb_react_avg.sv
// Directed/randomized bench for react_avg against a list-of-samples reference model.
module tb_react_avg;
   import react_avg_pkg::*;

   logic       clk;
   logic       rstn;
   logic [2:0] machine_state;
   logic       cur_player;
   logic [9:0] react_time;
   logic       react_valid;
   logic [2:0] test_turn_A, test_turn_B;
   logic [9:0] avr_react_time_A, avr_react_time_B;
   logic       done_A, done_B, avg_valid_A, avg_valid_B;

   react_avg dut (
      .clk              (clk),
      .rstn             (rstn),
      .machine_state    (machine_state),
      .cur_player       (cur_player),
      .react_time       (react_time),
      .react_valid      (react_valid),
      .test_turn_A      (test_turn_A),
      .test_turn_B      (test_turn_B),
      .avr_react_time_A (avr_react_time_A),
      .avr_react_time_B (avr_react_time_B),
      .done_A           (done_A),
      .done_B           (done_B),
      .avg_valid_A      (avg_valid_A),
      .avg_valid_B      (avg_valid_B)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model, indexed by player value (1 = A, 0 = B).
   int samples[2][$];
   int model_avg[2];
   bit model_avv[2];

   function automatic int model_sum(int p);
      int s = 0;
      foreach (samples[p][i]) s += samples[p][i];
      return s;
   endfunction

   function automatic int model_turn(int p);
      return (samples[p].size() > 7) ? 7 : samples[p].size();
   endfunction

   function automatic bit model_done(int p);
      return samples[p].size() == 8;
   endfunction

   function automatic void model_clear();
      for (int p = 0; p < 2; p++) begin
         samples[p].delete();
         model_avg[p] = 0;
         model_avv[p] = 1'b0;
      end
   endfunction

   function automatic void model_store(int p, int t);
      if (samples[p].size() < 8)
         samples[p].push_back((t > 999) ? 999 : t);
   endfunction

   function automatic logic [31:0] obs_turn(int p);
      return p ? 32'(test_turn_A) : 32'(test_turn_B);
   endfunction
   function automatic logic [31:0] obs_avg(int p);
      return p ? 32'(avr_react_time_A) : 32'(avr_react_time_B);
   endfunction
   function automatic logic [31:0] obs_done(int p);
      return p ? 32'(done_A) : 32'(done_B);
   endfunction
   function automatic logic [31:0] obs_avv(int p);
      return p ? 32'(avg_valid_A) : 32'(avg_valid_B);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int p = 0; p < 2; p++) begin
         string who;
         who = p ? "A" : "B";
         chk({tag, " turn_", who},  obs_turn(p), 32'(model_turn(p)));
         chk({tag, " done_", who},  obs_done(p), 32'(model_done(p)));
         chk({tag, " avg_", who},   obs_avg(p),  32'(model_avg[p]));
         chk({tag, " avgv_", who},  obs_avv(p),  32'(model_avv[p]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_trial(input int p, input int t);
      cur_player    = p[0];
      machine_state = ST_STORAGE;
      react_time    = t[9:0];
      react_valid   = 1'b1;
      tick();
      react_valid = 1'b0;
      tick();
      machine_state = ST_WAIT;
      tick();
      model_store(p, t);
   endtask

   task automatic do_average(input int p, input int cycles, input string tag);
      bit old_avv;
      old_avv       = model_avv[p];
      cur_player    = p[0];
      machine_state = ST_AVERAGE;
      if (model_done(p)) model_avg[p] = model_sum(p) / 8;
      tick();
      chk({tag, " avg_first"},  obs_avg(p), 32'(model_avg[p]));
      chk({tag, " avgv_first"}, obs_avv(p), 32'(old_avv));
      tick();
      if (model_done(p)) model_avv[p] = 1'b1;
      for (int i = 2; i < cycles; i++) tick();
      check_all({tag, " in_avg"});
      machine_state = ST_COMPARE;
      tick();
      tick();
      check_all({tag, " compare"});
   endtask

   task automatic do_idle();
      machine_state = ST_IDLE;
      tick();
      model_clear();
      machine_state = ST_WAIT;
      tick();
   endtask

   initial begin
      rstn          = 1'b0;
      machine_state = ST_IDLE;
      cur_player    = PLAYER_A;
      react_time    = '0;
      react_valid   = 1'b0;
      model_clear();
      repeat (3) tick();
      check_all("reset");
      rstn = 1'b1;
      machine_state = ST_WAIT;
      tick();

      // Player A: eight 200 ms trials
      for (int i = 0; i < 8; i++) begin
         do_trial(1, 200);
         check_all($sformatf("a200 #%0d", i));
      end
      do_average(0, 2, "b_not_done");
      do_average(1, 4, "a200");
      chk("a200 value", 32'(avr_react_time_A), 32'd200);

      // 9th store ignored, then IDLE clears everything
      do_trial(1, 500);
      check_all("ninth");
      do_idle();
      check_all("idle_clear");

      // Player B: 100..107 -> 828 / 8 = 103
      for (int i = 0; i < 8; i++) do_trial(0, 100 + i);
      check_all("b_ramp");
      do_average(0, 2, "b_ramp");
      chk("b_ramp value", 32'(avr_react_time_B), 32'd103);
      do_idle();

      // Clamp: 1023 stored as 999
      for (int i = 0; i < 8; i++) do_trial(1, 1023);
      do_average(1, 2, "clamp");
      chk("clamp value", 32'(avr_react_time_A), 32'd999);
      do_idle();

      // Double pulse in one visit, player switch mid-visit, pulse in WAIT
      cur_player    = PLAYER_A;
      machine_state = ST_STORAGE;
      react_time    = 10'd300;
      react_valid   = 1'b1;
      tick();
      react_valid = 1'b0;
      tick();
      react_valid = 1'b1;
      tick();
      cur_player = PLAYER_B;
      tick();
      react_valid   = 1'b0;
      machine_state = ST_WAIT;
      model_store(1, 300);
      react_valid = 1'b1;
      tick();
      react_valid = 1'b0;
      tick();
      check_all("double_pulse");
      do_idle();

      // Randomized interleaved trials
      for (int i = 0; i < 24; i++) begin
         do_trial(int'($urandom_range(0, 1)), int'($urandom_range(0, 1023)));
         check_all($sformatf("rand #%0d", i));
      end
      do_average(1, int'($urandom_range(2, 5)), "rand_a");
      do_average(0, int'($urandom_range(2, 5)), "rand_b");
      do_idle();

      // Asynchronous reset after four stores
      for (int i = 0; i < 4; i++) do_trial(1, int'($urandom_range(0, 1023)));
      check_all("pre_reset");
      #3 rstn = 1'b0;
      #1;
      model_clear();
      check_all("async_reset");
      #1 rstn = 1'b1;
      tick();
      do_trial(1, 250);
      check_all("post_reset");
      chk("post_reset turn", 32'(test_turn_A), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
